video_scanner: RTL and testbench

VIDEO_SCANNER -- requirements
Module: video_scanner

---
 rtl/video_scanner_if.sv | 18 +
 rtl/video_scanner.sv | 135 +++++++++++++
 tb/tb_video_scanner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_scanner_if.sv
// Video RAM read port shared between the scanner (master) and the RAM (slave).
interface video_scanner_if;
   logic [10:0] read_ad;
   logic        read_wre;
   logic [7:0]  read_data;

   modport master (
      output read_ad,
      output read_wre,
      input  read_data
   );

   modport slave (
      input  read_ad,
      input  read_wre,
      output read_data
   );
endinterface

// File: rtl/video_scanner.sv
// 128x128 monochrome raster scanner. Free-running h/v counters drive a byte-wide
// video RAM fetch every 8 pixels. Timing outputs are delayed to line up with the
// RAM data, so all outputs share a latency of READ_LATENCY+1 clocks.
module video_scanner #(
   parameter int H_FP         = 8,
   parameter int H_SYNC       = 16,
   parameter int H_BP         = 8,
   parameter int V_FP         = 2,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   blank,
   video_scanner_if.master        bus,
   output logic                   pixel,
   output logic                   de,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   frame_start
);

   localparam int H_TOTAL = 128 + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = 128 + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int RL      = READ_LATENCY;

   localparam logic [H_W-1:0] H_ACT    = H_W'(128);
   localparam logic [H_W-1:0] H_SYNC_S = H_W'(128 + H_FP);
   localparam logic [H_W-1:0] H_SYNC_E = H_W'(128 + H_FP + H_SYNC);
   localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT    = V_W'(128);
   localparam logic [V_W-1:0] V_SYNC_S = V_W'(128 + V_FP);
   localparam logic [V_W-1:0] V_SYNC_E = V_W'(128 + V_FP + V_SYNC);
   localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);

   logic [H_W-1:0] hcount_q, hcount_d;
   logic [V_W-1:0] vcount_q, vcount_d;
   logic           de_int, hsync_int, vsync_int, fs_int, issue_int;
   logic [10:0]    read_ad_q, read_ad_d;
   logic [7:0]     shift_q, shift_d;
   logic           pixel_q, pixel_d;
   logic           de_q, hsync_q, vsync_q, fs_q;

   // Stage RL-1 of each pipe feeds the output registers; ld marks the clock
   // on which the RAM byte for a fetch is valid on read_data.
   logic [RL-1:0]  de_pipe_q, hs_pipe_q, vs_pipe_q, fs_pipe_q, ld_pipe_q;

   // Counter advance, raster decode and the next pixel value.
   always_comb begin
      hcount_d = hcount_q + 1'b1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end
      de_int    = (hcount_q < H_ACT) && (vcount_q < V_ACT);
      hsync_int = !((hcount_q >= H_SYNC_S) && (hcount_q < H_SYNC_E));
      vsync_int = !((vcount_q >= V_SYNC_S) && (vcount_q < V_SYNC_E));
      fs_int    = (hcount_q == '0) && (vcount_q == '0);
      issue_int = de_int && (hcount_q[2:0] == 3'd0);
      read_ad_d = issue_int ? {vcount_q[6:0], hcount_q[6:3]} : read_ad_q;
      // The pixel register follows the new shift-register MSB so the pixel
      // shares the timing pipe latency instead of adding a clock.
      shift_d   = ld_pipe_q[RL-1] ? bus.read_data : {shift_q[6:0], 1'b0};
      pixel_d   = shift_d[7] && de_pipe_q[RL-1] && !blank;
   end

   // Raster counters and RAM address register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcount_q  <= '0;
         vcount_q  <= '0;
         read_ad_q <= '0;
      end else begin
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
         read_ad_q <= read_ad_d;
      end
   end

   // Delay pipes aligning timing signals with returned RAM data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_pipe_q <= '0;
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         fs_pipe_q <= '0;
         ld_pipe_q <= '0;
      end else begin
         de_pipe_q[0] <= de_int;
         hs_pipe_q[0] <= hsync_int;
         vs_pipe_q[0] <= vsync_int;
         fs_pipe_q[0] <= fs_int;
         ld_pipe_q[0] <= issue_int;
         for (int i = 1; i < RL; i++) begin
            de_pipe_q[i] <= de_pipe_q[i-1];
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
            fs_pipe_q[i] <= fs_pipe_q[i-1];
            ld_pipe_q[i] <= ld_pipe_q[i-1];
         end
      end
   end

   // Pixel shift register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         pixel_q <= 1'b0;
         de_q    <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         shift_q <= shift_d;
         pixel_q <= pixel_d;
         de_q    <= de_pipe_q[RL-1];
         hsync_q <= hs_pipe_q[RL-1];
         vsync_q <= vs_pipe_q[RL-1];
         fs_q    <= fs_pipe_q[RL-1];
      end
   end

   assign bus.read_ad  = read_ad_q;
   assign bus.read_wre = 1'b0;
   assign pixel        = pixel_q;
   assign de           = de_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign frame_start  = fs_q;

endmodule

// File: tb/tb_video_scanner.sv
// Directed bench for video_scanner: main instance at READ_LATENCY=2 plus
// instances at 1 and 4 for the latency comparison after a mid-frame reset.
module tb_video_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, blank;
   int   ram_mode;
   int   cyc;
   int   errors = 0;
   int   checks = 0;

   video_scanner_if bus1();
   video_scanner_if bus2();
   video_scanner_if bus4();

   logic pixel1, de1, hs1, vs1, fs1;
   logic pixel2, de2, hs2, vs2, fs2;
   logic pixel4, de4, hs4, vs4, fs4;

   video_scanner #(.READ_LATENCY(2)) dut (
      .clk(clk), .reset(reset), .blank(blank), .bus(bus2),
      .pixel(pixel2), .de(de2), .hsync(hs2), .vsync(vs2), .frame_start(fs2));

   video_scanner #(.READ_LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .blank(blank), .bus(bus1),
      .pixel(pixel1), .de(de1), .hsync(hs1), .vsync(vs1), .frame_start(fs1));

   video_scanner #(.READ_LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset), .blank(blank), .bus(bus4),
      .pixel(pixel4), .de(de4), .hsync(hs4), .vsync(vs4), .frame_start(fs4));

   // RAM contents: mode 1 is all 0xFF, otherwise low address byte with 0xA5 at 0x7FF.
   function automatic logic [7:0] ram_byte(input int mode, input logic [10:0] a);
      if (mode == 1) return 8'hFF;
      if (a == 11'h7FF) return 8'hA5;
      return a[7:0];
   endfunction

   // RAM models: READ_LATENCY-1 register stages in front of read_data.
   logic [7:0] r2_q;
   logic [7:0] r4_q [3];
   assign bus1.read_data = ram_byte(ram_mode, bus1.read_ad);
   always @(posedge clk) r2_q <= ram_byte(ram_mode, bus2.read_ad);
   assign bus2.read_data = r2_q;
   always @(posedge clk) begin
      r4_q[0] <= ram_byte(ram_mode, bus4.read_ad);
      r4_q[1] <= r4_q[0];
      r4_q[2] <= r4_q[1];
   end
   assign bus4.read_data = r4_q[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Frame statistics for the first frame after release (cyc 3..21762).
   logic mon_en = 1'b0;
   logic de_prev = 1'b0;
   int de_cnt = 0, de_rise = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
   int de_line = 0, hs_line = 0;
   always @(negedge clk) begin
      if (mon_en && cyc >= 3 && cyc <= 21762) begin
         if (de2) de_cnt++;
         if (de2 && !de_prev) de_rise++;
         if (!hs2) hs_low++;
         if (!vs2) vs_low++;
         if (fs2) fs_cnt++;
         if (cyc <= 162 && de2) de_line++;
         if (cyc <= 162 && !hs2) hs_line++;
         de_prev = de2;
      end
   end

   typedef struct {
      int   k;
      logic px, de, hs, vs, fs;
      int   ad;
   } vec_t;

   vec_t vt[$];
   logic fs_log [3][1:22];
   logic px_log [3][1:22];
   int   lat [3];

   initial begin
      // k = rising edges since release; outputs sampled just after edge k.
      vt.push_back('{1,     0, 0, 1, 1, 0, -1});
      vt.push_back('{2,     0, 0, 1, 1, 0, -1});
      vt.push_back('{3,     0, 1, 1, 1, 1, -1});
      vt.push_back('{4,     0, 1, 1, 1, 0, -1});
      vt.push_back('{17,    0, 1, 1, 1, 0, -1});
      vt.push_back('{18,    1, 1, 1, 1, 0, -1});
      vt.push_back('{19,    0, 1, 1, 1, 0, -1});
      vt.push_back('{130,   1, 1, 1, 1, 0, -1});
      vt.push_back('{131,   0, 0, 1, 1, 0, -1});
      vt.push_back('{138,   0, 0, 1, 1, 0, -1});
      vt.push_back('{139,   0, 0, 0, 1, 0, -1});
      vt.push_back('{154,   0, 0, 0, 1, 0, -1});
      vt.push_back('{155,   0, 0, 1, 1, 0, -1});
      vt.push_back('{163,   0, 1, 1, 1, 0, -1});
      vt.push_back('{166,   1, 1, 1, 1, 0, -1});
      vt.push_back('{20440, 1, 1, 1, 1, 0, 'h7FE});
      vt.push_back('{20441, 1, 1, 1, 1, 0, 'h7FF});
      vt.push_back('{20443, 1, 1, 1, 1, 0, -1});
      vt.push_back('{20444, 0, 1, 1, 1, 0, -1});
      vt.push_back('{20445, 1, 1, 1, 1, 0, -1});
      vt.push_back('{20446, 0, 1, 1, 1, 0, -1});
      vt.push_back('{20447, 0, 1, 1, 1, 0, -1});
      vt.push_back('{20448, 1, 1, 1, 1, 0, -1});
      vt.push_back('{20449, 0, 1, 1, 1, 0, -1});
      vt.push_back('{20450, 1, 1, 1, 1, 0, -1});
      vt.push_back('{20451, 0, 0, 1, 1, 0, 'h7FF});
      vt.push_back('{20802, 0, 0, 1, 1, 0, -1});
      vt.push_back('{20803, 0, 0, 1, 0, 0, -1});
      vt.push_back('{21122, 0, 0, 1, 0, 0, -1});
      vt.push_back('{21123, 0, 0, 1, 1, 0, -1});
      vt.push_back('{21762, 0, 0, 1, 1, 0, -1});
      vt.push_back('{21763, 0, 1, 1, 1, 1, -1});
      vt.push_back('{21764, 0, 1, 1, 1, 0, -1});

      reset = 1'b0;
      blank = 1'b0;
      ram_mode = 0;
      cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_de", de2, 0);
      chk("rst_hsync", hs2, 1);
      chk("rst_vsync", vs2, 1);
      chk("rst_fs", fs2, 0);
      chk("rst_pixel", pixel2, 0);
      chk("rst_read_ad", bus2.read_ad, 0);
      chk("rst_read_wre", bus2.read_wre, 0);

      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      mon_en = 1'b1;
      foreach (vt[i]) begin
         while (cyc < vt[i].k) step();
         chk($sformatf("pixel@%0d", vt[i].k), pixel2, vt[i].px);
         chk($sformatf("de@%0d", vt[i].k), de2, vt[i].de);
         chk($sformatf("hsync@%0d", vt[i].k), hs2, vt[i].hs);
         chk($sformatf("vsync@%0d", vt[i].k), vs2, vt[i].vs);
         chk($sformatf("frame_start@%0d", vt[i].k), fs2, vt[i].fs);
         if (vt[i].ad >= 0) chk($sformatf("read_ad@%0d", vt[i].k), bus2.read_ad, vt[i].ad);
      end
      mon_en = 1'b0;
      chk("frame_de_clocks", de_cnt, 16384);
      chk("frame_de_lines", de_rise, 128);
      chk("frame_hsync_low", hs_low, 2176);
      chk("frame_vsync_low", vs_low, 320);
      chk("frame_start_count", fs_cnt, 1);
      chk("line_de_clocks", de_line, 128);
      chk("line_hsync_low", hs_line, 16);

      // Blank for 4 clocks mid-line with an all-ones RAM.
      ram_mode = 1;
      while (cyc < 22603) step();
      chk("blank_pre_pixel", pixel2, 1);
      blank = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("blank_pixel_%0d", i), pixel2, 0);
         chk($sformatf("blank_de_%0d", i), de2, 1);
         chk($sformatf("blank_hsync_%0d", i), hs2, 1);
      end
      blank = 1'b0;
      step();
      chk("blank_post_pixel", pixel2, 1);

      // Asynchronous reset at line 50, h=60 of the next frame.
      while (cyc < 29823) step();
      chk("pre_reset_de", de2, 1);
      chk("pre_reset_pixel", pixel2, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_de", de2, 0);
      chk("async_pixel", pixel2, 0);
      chk("async_hsync", hs2, 1);
      chk("async_vsync", vs2, 1);
      chk("async_fs", fs2, 0);
      chk("async_read_ad", bus2.read_ad, 0);
      chk("async_read_wre", bus2.read_wre, 0);
      chk("async_de_l1", de1, 0);
      chk("async_de_l4", de4, 0);
      ram_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      for (int k = 1; k <= 22; k++) begin
         step();
         fs_log[0][k] = fs1;
         fs_log[1][k] = fs2;
         fs_log[2][k] = fs4;
         px_log[0][k] = pixel1;
         px_log[1][k] = pixel2;
         px_log[2][k] = pixel4;
      end
      lat[0] = 2;
      lat[1] = 3;
      lat[2] = 5;
      for (int n = 0; n < 3; n++) begin
         for (int k = 1; k <= 22; k++) begin
            chk($sformatf("relat%0d_fs@%0d", lat[n], k), fs_log[n][k], (k == lat[n]) ? 1 : 0);
            chk($sformatf("relat%0d_pixel@%0d", lat[n], k), px_log[n][k], (k == lat[n] + 15) ? 1 : 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
